multicycle_adder: RTL and testbench
===================================

MULTICYCLE_ADDER -- requirements
Module: multicycle_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand and sum width in bits.
REQ-002 The block SHALL have parameter CHUNK, default 4, giving the bits added per clock; WIDTH SHALL be an integer multiple of CHUNK, and CHUNK >= 1.
REQ-003 The block SHALL have clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 The block SHALL have reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have in_valid, input, 1 bit: the operands are presented.
REQ-006 The block SHALL have in_ready, output, 1 bit: the block can accept operands.
REQ-007 The block SHALL have a and b, inputs, WIDTH bits each: the two's-complement operands.
REQ-008 The block SHALL have subtract, input, 1 bit: 0 computes a+b; 1 computes a-b.
REQ-009 The block SHALL have out_valid, output, 1 bit: the result is held and valid.
REQ-010 The block SHALL have out_ready, input, 1 bit: the consumer accepts the result.
REQ-011 The block SHALL have sum, output, WIDTH bits: the result.
REQ-012 The block SHALL have carryout, output, 1 bit: the carry out of the MSB.
REQ-013 The block SHALL have overflow, output, 1 bit: signed overflow.
REQ-014 The block SHALL have busy, output, 1 bit: high in the RUN state.

Function
REQ-015 The state machine SHALL have exactly three states, IDLE, RUN and DONE; NCHUNK = WIDTH/CHUNK.
REQ-016 IDLE SHALL drive in_ready=1 and out_valid=0; in_valid=1 at an edge captures a, b XOR {WIDTH{subtract}} and carry-in=subtract, clears the chunk index, and moves to RUN.
REQ-017 RUN SHALL drive in_ready=0, and each cycle SHALL add chunk[index] of the captured operands with the running carry, write that chunk of sum, store the carry, and increment the index.
REQ-018 Chunks SHALL be processed LSB chunk first; after chunk NCHUNK-1 the block SHALL move to DONE.
REQ-019 Latency SHALL be fixed: out_valid rises exactly NCHUNK cycles after the accepting edge, independent of the operand values.
REQ-020 DONE SHALL drive out_valid=1 with sum, carryout and overflow stable; out_ready=1 at an edge moves the block to IDLE.
REQ-021 A new input SHALL NOT be accepted in the same cycle the result is consumed; throughput is one result per NCHUNK+2 cycles minimum.
REQ-022 carryout SHALL be the raw carry from bit WIDTH-1 of a + b' + cin; for subtraction, 1 means no borrow.
REQ-023 overflow SHALL equal carry-into-MSB XOR carry-out-of-MSB.
REQ-024 Input changes while in RUN or DONE SHALL have no effect; the captured operands are not modified.
REQ-025 If out_ready stays low indefinitely, DONE and the result SHALL persist with no timeout.
REQ-026 With NCHUNK=1, RUN SHALL last exactly one cycle.

Reset
REQ-027 When reset is high at an edge, the state SHALL go to IDLE, the index and stored carry to 0, and sum to 0.
REQ-028 After reset, in_ready SHALL be 1, and out_valid, carryout, overflow and busy SHALL be 0.
REQ-029 Reset SHALL take priority over every handshake; a reset in RUN or DONE SHALL discard the operation with no result produced.

Structure
REQ-030 The package adder_pkg SHALL hold the state enum (IDLE, RUN, DONE) and the default WIDTH and CHUNK constants.
REQ-031 A sub-module chunk_adder SHALL implement a CHUNK-bit ripple adder with outputs sum, carry-out and carry-into-MSB; it SHALL be instantiated once and reused every cycle.

Verification
REQ-032 Scenario: WIDTH=4, CHUNK=1, a=0101, b=0100, add -> after 4 cycles, sum=1001, carryout=0, overflow=1.
REQ-033 Scenario: WIDTH=4, CHUNK=1, a=1000, b=1110, add -> sum=0110, carryout=1, overflow=1; a=1011, b=1111 -> sum=1010, carryout=1, overflow=0.
REQ-034 Scenario: WIDTH=32, CHUNK=4, a=0x00000005, b=0x00000007, subtract -> sum=0xFFFFFFFE, carryout=0, overflow=0; a=0x80000000, b=1, subtract -> sum=0x7FFFFFFF, overflow=1.
REQ-035 Scenario: hold out_ready=0 for 10 cycles in DONE -> out_valid stays 1, the result stays stable, and in_ready stays 0; while there, toggle a and b -> no effect.
REQ-036 Scenario: assert reset for one cycle in the 3rd RUN cycle -> next cycle in IDLE with in_ready=1 and out_valid=0, and no result is emitted.
REQ-037 Scenario: back-to-back operations with out_ready tied to 1 -> each out_valid pulse lasts one cycle, and acceptances are spaced exactly NCHUNK+2 cycles apart.

Source files
------------

// File: rtl/adder_pkg.sv
// adder_pkg: shared state encoding, default sizes and index-width helper for the multicycle adder.
package adder_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
    localparam int DEF_WIDTH = 32;
    localparam int DEF_CHUNK = 4;
    function automatic int idx_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/chunk_adder.sv
// chunk_adder: CHUNK-bit adder slice returning sum, carry-out and the carry into its MSB.
module chunk_adder #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a_i,
    input  logic [CHUNK-1:0] b_i,
    input  logic             cin_i,
    output logic [CHUNK-1:0] sum_o,
    output logic             cout_o,
    output logic             cmsb_o
);
    assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {{CHUNK{1'b0}}, cin_i};
    // The MSB sum bit is a^b^cin, so the carry into it falls out by XOR.
    assign cmsb_o = a_i[CHUNK-1] ^ b_i[CHUNK-1] ^ sum_o[CHUNK-1];
endmodule

// File: rtl/multicycle_adder.sv
// multicycle_adder: adds or subtracts two WIDTH-bit operands CHUNK bits per clock, LSB chunk first,
// behind a valid/ready handshake on both sides.
module multicycle_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CHUNK = DEF_CHUNK
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             subtract,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carryout,
    output logic             overflow,
    output logic             busy
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IW = idx_bits(NCHUNK);
    localparam logic [IW-1:0] LAST = IW'(NCHUNK - 1);

    state_e state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic carry_q, carry_d, ovf_q, ovf_d;
    logic [CHUNK-1:0] chunk_sum;
    logic chunk_cout, chunk_cmsb;

    chunk_adder #(.CHUNK(CHUNK)) u_chunk (
        .a_i   (a_q[idx_q*CHUNK +: CHUNK]),
        .b_i   (b_q[idx_q*CHUNK +: CHUNK]),
        .cin_i (carry_q),
        .sum_o (chunk_sum),
        .cout_o(chunk_cout),
        .cmsb_o(chunk_cmsb)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: if (in_valid) begin
                a_d     = a;
                b_d     = b ^ {WIDTH{subtract}};
                carry_d = subtract;
                ovf_d   = 1'b0;
                idx_d   = '0;
                state_d = RUN;
            end
            RUN: begin
                sum_d[idx_q*CHUNK +: CHUNK] = chunk_sum;
                carry_d = chunk_cout;
                idx_d   = (idx_q == LAST) ? '0 : idx_q + 1'b1;
                if (idx_q == LAST) begin
                    ovf_d   = chunk_cmsb ^ chunk_cout;
                    state_d = DONE;
                end
            end
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q == RUN);
    assign sum       = sum_q;
    assign carryout  = carry_q;
    assign overflow  = ovf_q;
endmodule

// File: tb/tb_multicycle_adder.sv
// tb_multicycle_adder: scoreboard bench for a 32/4 and a 4/1 instance of the multicycle adder.
module tb_multicycle_adder;
    typedef struct packed {
        logic [31:0] s;
        logic        c;
        logic        v;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int nc = 0;
    int nf = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    exp_t q32[$];
    exp_t q4[$];

    logic rst32 = 1'b1, iv32 = 1'b0, s32 = 1'b0, or32 = 1'b0;
    logic [31:0] a32 = '0, b32 = '0;
    logic ir32, ov32, co32, of32, bz32;
    logic [31:0] sum32;

    logic rst4 = 1'b1, iv4 = 1'b0, s4 = 1'b0, or4 = 1'b0;
    logic [3:0] a4 = '0, b4 = '0;
    logic ir4, ov4, co4, of4, bz4;
    logic [3:0] sum4;

    multicycle_adder #(.WIDTH(32), .CHUNK(4)) u32 (
        .clk(clk), .reset(rst32), .in_valid(iv32), .in_ready(ir32), .a(a32), .b(b32),
        .subtract(s32), .out_valid(ov32), .out_ready(or32), .sum(sum32),
        .carryout(co32), .overflow(of32), .busy(bz32)
    );

    multicycle_adder #(.WIDTH(4), .CHUNK(1)) u4 (
        .clk(clk), .reset(rst4), .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4),
        .subtract(s4), .out_valid(ov4), .out_ready(or4), .sum(sum4),
        .carryout(co4), .overflow(of4), .busy(bz4)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        nc++;
        if (got !== exp) begin
            nf++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Monitors: pop an expectation whenever a result is consumed.
    logic prev4 = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (ov32 && or32) begin
            if (q32.size() == 0) chk("unexpected32", 32'(ov32), 32'd0);
            else begin
                e = q32.pop_front();
                chk("sum32", sum32, e.s);
                chk("cout32", 32'(co32), 32'(e.c));
                chk("ovf32", 32'(of32), 32'(e.v));
            end
        end
        if (ov4 && or4) begin
            chk("pulse4", 32'(prev4), 32'd0);
            if (q4.size() == 0) chk("unexpected4", 32'(ov4), 32'd0);
            else begin
                e = q4.pop_front();
                chk("sum4", {28'd0, sum4}, e.s);
                chk("cout4", 32'(co4), 32'(e.c));
                chk("ovf4", 32'(of4), 32'(e.v));
            end
            prev4 = 1'b1;
        end else prev4 = 1'b0;
    end

    task automatic op32(input logic [31:0] x, input logic [31:0] y, input logic s,
                        input logic [31:0] es, input logic ec, input logic ev, input bit hold);
        int lat;
        q32.push_back('{es, ec, ev});
        a32 = x; b32 = y; s32 = s; iv32 = 1'b1;
        chk("in_ready32", 32'(ir32), 32'd1);
        @(posedge clk); #1;
        iv32 = 1'b0;
        lat = 0;
        do begin @(posedge clk); #1; lat++; end while (!ov32 && lat < 40);
        chk("latency32", 32'(lat), 32'd8);
        if (hold) begin
            for (int i = 0; i < 10; i++) begin
                a32 = ~a32; b32 = b32 + 32'd3; s32 = ~s32; iv32 = 1'b1;
                @(posedge clk); #1;
                chk("hold_valid", 32'(ov32), 32'd1);
                chk("hold_ready", 32'(ir32), 32'd0);
                chk("hold_sum", sum32, es);
            end
            iv32 = 1'b0;
        end
        or32 = 1'b1;
        @(posedge clk); #1;
        or32 = 1'b0;
        chk("idle32", 32'(ir32), 32'd1);
    endtask

    task automatic op4(input logic [3:0] x, input logic [3:0] y, input logic s,
                       input logic [3:0] es, input logic ec, input logic ev);
        int lat;
        q4.push_back('{{28'd0, es}, ec, ev});
        a4 = x; b4 = y; s4 = s; iv4 = 1'b1;
        chk("in_ready4", 32'(ir4), 32'd1);
        @(posedge clk); #1;
        iv4 = 1'b0;
        lat = 0;
        do begin @(posedge clk); #1; lat++; end while (!ov4 && lat < 40);
        chk("latency4", 32'(lat), 32'd4);
        or4 = 1'b1;
        @(posedge clk); #1;
        or4 = 1'b0;
    endtask

    initial begin
        int acc[3];
        logic [3:0] ba[3], bb[3], bs[3];
        logic bc[3], bv[3];
        int n;
        repeat (2) @(posedge clk);
        #1;
        rst32 = 1'b0; rst4 = 1'b0;
        chk("rst_ready32", 32'(ir32), 32'd1);
        chk("rst_valid32", 32'(ov32), 32'd0);
        chk("rst_busy32", 32'(bz32), 32'd0);
        chk("rst_flags32", {30'd0, co32, of32}, 32'd0);
        chk("rst_sum32", sum32, 32'd0);
        chk("rst_ready4", 32'(ir4), 32'd1);
        chk("rst_valid4", 32'(ov4), 32'd0);

        op4(4'b0101, 4'b0100, 1'b0, 4'b1001, 1'b0, 1'b1);
        op4(4'b1000, 4'b1110, 1'b0, 4'b0110, 1'b1, 1'b1);
        op4(4'b1011, 4'b1111, 1'b0, 4'b1010, 1'b1, 1'b0);
        op4(4'b0011, 4'b0101, 1'b1, 4'b1110, 1'b0, 1'b0);

        op32(32'h0000_0005, 32'h0000_0007, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
        op32(32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
        op32(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b0);
        op32(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
        op32(32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 32'hACF1_3568, 1'b0, 1'b0, 1'b1);
        op32(32'h0000_0010, 32'h0000_0010, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b0);

        // Reset during the third RUN cycle: nothing may be emitted afterwards.
        a4 = 4'b0111; b4 = 4'b0111; s4 = 1'b0; iv4 = 1'b1;
        @(posedge clk); #1;
        iv4 = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("busy_before_rst", 32'(bz4), 32'd1);
        rst4 = 1'b1;
        @(posedge clk); #1;
        rst4 = 1'b0;
        or4 = 1'b1;
        chk("abort_ready", 32'(ir4), 32'd1);
        chk("abort_valid", 32'(ov4), 32'd0);
        chk("abort_busy", 32'(bz4), 32'd0);
        n = 0;
        repeat (8) begin @(posedge clk); #1; n += int'(ov4); end
        chk("abort_no_result", 32'(n), 32'd0);

        // Back-to-back with out_ready tied high.
        ba = '{4'b0001, 4'b0111, 4'b1111};
        bb = '{4'b0001, 4'b0001, 4'b0001};
        bs = '{4'b0010, 4'b1000, 4'b0000};
        bc = '{1'b0, 1'b0, 1'b1};
        bv = '{1'b0, 1'b1, 1'b0};
        iv4 = 1'b1;
        for (int k = 0; k < 3; k++) begin
            a4 = ba[k]; b4 = bb[k]; s4 = 1'b0;
            q4.push_back('{{28'd0, bs[k]}, bc[k], bv[k]});
            n = 0;
            while (!ir4 && n < 20) begin @(posedge clk); #1; n++; end
            chk("b2b_wait", 32'(n < 20), 32'd1);
            @(posedge clk); #1;
            acc[k] = cyc;
        end
        iv4 = 1'b0;
        chk("b2b_gap0", 32'(acc[1] - acc[0]), 32'd6);
        chk("b2b_gap1", 32'(acc[2] - acc[1]), 32'd6);
        repeat (10) @(posedge clk);
        #1;
        or4 = 1'b0;
        chk("q32_drained", 32'(q32.size()), 32'd0);
        chk("q4_drained", 32'(q4.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nc, nf);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end
endmodule
